// File: rtl/fir_axis_out_fifo_if.sv
// AXI-Stream link carrying FIR samples with an end-of-frame marker.
//
// Handshake: a beat transfers on a rising clk edge where tvalid and tready
// are both high. Once the master raises tvalid it holds tdata/tlast stable
// and keeps tvalid high until that transfer happens. The master never waits
// on tready before asserting tvalid.
interface fir_axis_out_fifo_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/fir_axis_out_fifo.sv
// First-word-fall-through AXI-Stream FIFO placed after the FIR pipeline.
// Gives the FIR real backpressure, counts delivered frames and reports fill
// level. Input ready depends only on the stored count, so there is no
// combinational path from the consumer's ready back to the FIR.
module fir_axis_out_fifo #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 4,
  parameter int ALMOST_FULL_TH  = 12,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  fir_axis_out_fifo_if.slave         s_axis,
  fir_axis_out_fifo_if.master        m_axis,
  output logic [ADDR_WIDTH:0]        fill_level,
  output logic                       almost_full,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       overflow_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]        DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]        AF_TH_C = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0]        CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0]      PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [FRAME_CNT_WIDTH-1:0] FC_ONE  = FRAME_CNT_WIDTH'(1);

  // Storage word is {tlast, tdata}
  logic [DATA_WIDTH:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]        count_q, count_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic                       overflow_err_q, overflow_err_d;

  logic                s_ready;
  logic                m_valid;
  logic                push;
  logic                pop;
  logic [DATA_WIDTH:0] head_word;

  // Handshake decode, pointer/count/frame/error next-state
  always_comb begin
    s_ready        = (count_q != DEPTH_C);
    m_valid        = (count_q != '0);
    push           = s_axis.tvalid & s_ready;
    pop            = m_valid & m_axis.tready;
    head_word      = mem_q[rd_ptr_q];
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    frame_count_d  = frame_count_q;
    overflow_err_d = overflow_err_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Frame completes when its last beat leaves the FIFO
    if (pop && head_word[DATA_WIDTH]) frame_count_d = frame_count_q + FC_ONE;

    // A frame end held off by a full FIFO is flagged for debug
    if (s_axis.tvalid && !s_ready && s_axis.tlast) overflow_err_d = 1'b1;
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      frame_count_q  <= '0;
      overflow_err_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      frame_count_q  <= frame_count_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  // Sample storage; contents are not cleared since pointers define validity
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= {s_axis.tlast, s_axis.tdata};
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = head_word[DATA_WIDTH-1:0];
  assign m_axis.tlast  = m_valid & head_word[DATA_WIDTH];
  assign fill_level    = count_q;
  assign almost_full   = (count_q >= AF_TH_C);
  assign frame_count   = frame_count_q;
  assign overflow_err  = overflow_err_q;

endmodule

// File: tb/tb_fir_axis_out_fifo.sv
// Self-checking bench for fir_axis_out_fifo. A queue of accepted beats is
// the reference; a negedge scoreboard compares every output each cycle and
// the scenario tasks check the directed expectations inline.
module tb_fir_axis_out_fifo;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF_TH = 12;
  localparam int FW    = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fir_axis_out_fifo_if #(.DATA_WIDTH(DW)) s_axis ();
  fir_axis_out_fifo_if #(.DATA_WIDTH(DW)) m_axis ();

  logic [AW:0]   fill_level;
  logic          almost_full;
  logic [FW-1:0] frame_count;
  logic          overflow_err;

  fir_axis_out_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF_TH), .FRAME_CNT_WIDTH(FW)
  ) dut (
    .clk(clk), .reset(reset), .s_axis(s_axis), .m_axis(m_axis),
    .fill_level(fill_level), .almost_full(almost_full),
    .frame_count(frame_count), .overflow_err(overflow_err)
  );

  // ---------------- reference model ----------------
  logic [DW:0] exp_q[$];   // beats held by the FIFO, {tlast, tdata}
  logic [DW:0] rx_q[$];    // beats delivered to the consumer
  logic [DW:0] src_q[$];   // beats the source still has to send
  int unsigned exp_frames = 0;
  bit exp_ovf = 1'b0;
  bit last_push = 1'b0;
  bit sb_en = 1'b0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) begin
    bit push, pop;
    logic [DW:0] w;
    push = !reset && s_axis.tvalid && (exp_q.size() != DEPTH);
    pop  = !reset && m_axis.tready && (exp_q.size() != 0);
    last_push = push;
    if (reset) begin
      exp_q.delete();
      exp_frames = 0;
      exp_ovf = 1'b0;
    end else begin
      if (s_axis.tvalid && s_axis.tlast && exp_q.size() == DEPTH) exp_ovf = 1'b1;
      if (pop) begin
        w = exp_q.pop_front();
        rx_q.push_back(w);
        if (w[DW]) exp_frames = (exp_frames + 1) % (1 << FW);
      end
      if (push) exp_q.push_back({s_axis.tlast, s_axis.tdata});
    end
  end

  // Per-cycle scoreboard, sampled away from the active edge
  always @(negedge clk) begin
    if (sb_en && !reset) begin
      checks++;
      if (s_axis.tready !== (exp_q.size() != DEPTH) ||
          m_axis.tvalid !== (exp_q.size() != 0) ||
          fill_level !== (AW+1)'(exp_q.size()) ||
          almost_full !== (exp_q.size() >= AF_TH) ||
          frame_count !== FW'(exp_frames) ||
          overflow_err !== exp_ovf) begin
        failures++;
        $display("FAIL sb_status t=%0t got rdy=%b vld=%b fill=%0d af=%b fc=%0d ovf=%b exp fill=%0d fc=%0d ovf=%b",
                 $time, s_axis.tready, m_axis.tvalid, fill_level, almost_full, frame_count,
                 overflow_err, exp_q.size(), exp_frames, exp_ovf);
      end
      checks++;
      if (exp_q.size() != 0) begin
        if ({m_axis.tlast, m_axis.tdata} !== exp_q[0]) begin
          failures++;
          $display("FAIL sb_head t=%0t got %h exp %h", $time, {m_axis.tlast, m_axis.tdata}, exp_q[0]);
        end
      end else if (m_axis.tlast !== 1'b0) begin
        failures++;
        $display("FAIL sb_empty_tlast t=%0t got %b exp 0", $time, m_axis.tlast);
      end
    end
  end

  // ---------------- drivers ----------------
  // One clock cycle: source presents its head beat, consumer ready with
  // probability ready_pct. Returns #1 after the edge.
  task automatic drive_cycle(input int ready_pct);
    s_axis.tvalid = (src_q.size() != 0);
    if (src_q.size() != 0) begin
      s_axis.tdata = src_q[0][DW-1:0];
      s_axis.tlast = src_q[0][DW];
    end else begin
      s_axis.tlast = 1'b0;
    end
    m_axis.tready = ($urandom_range(0, 99) < ready_pct);
    @(posedge clk);
    #1;
    if (last_push) void'(src_q.pop_front());
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_cycle(0);
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      drive_cycle(100);
      n++;
    end
    checks++;
    if (src_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout src_left=%0d fifo_left=%0d exp 0", src_q.size(), exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0; m_axis.tready = 1'b0;
    do_reset();
    sb_en = 1'b1;
    checks++;
    if (s_axis.tready !== 1'b1 || m_axis.tvalid !== 1'b0 || m_axis.tlast !== 1'b0 ||
        fill_level !== '0 || almost_full !== 1'b0 || frame_count !== '0 || overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b last=%b fill=%0d af=%b fc=%0d ovf=%b exp 1 0 0 0 0 0 0",
               s_axis.tready, m_axis.tvalid, m_axis.tlast, fill_level, almost_full, frame_count, overflow_err);
    end
  endtask

  task automatic test_single_beat();
    src_q.push_back({1'b1, 16'h1234});
    drive_cycle(100);
    checks++;
    if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 16'h1234 || m_axis.tlast !== 1'b1 || fill_level !== 5'd1) begin
      failures++;
      $display("FAIL single_out got vld=%b data=%h last=%b fill=%0d exp 1 1234 1 1",
               m_axis.tvalid, m_axis.tdata, m_axis.tlast, fill_level);
    end
    drive_cycle(100);
    checks++;
    if (frame_count !== 16'd1 || fill_level !== 5'd0 || m_axis.tvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_pop got fc=%0d fill=%0d vld=%b exp 1 0 0", frame_count, fill_level, m_axis.tvalid);
    end
  endtask

  task automatic test_fill_full();
    int accepted = 0;
    rx_q.delete();
    for (int i = 0; i < 20; i++) src_q.push_back({1'b0, 16'(i)});
    for (int c = 0; c < 20; c++) begin
      drive_cycle(0);
      if (last_push) accepted++;
      checks++;
      if (almost_full !== (accepted >= AF_TH)) begin
        failures++;
        $display("FAIL full_almost cyc=%0d got %b exp %b", c, almost_full, accepted >= AF_TH);
      end
    end
    checks++;
    if (accepted != 16 || s_axis.tready !== 1'b0 || fill_level !== 5'd16) begin
      failures++;
      $display("FAIL full_state got acc=%0d rdy=%b fill=%0d exp 16 0 16", accepted, s_axis.tready, fill_level);
    end
    drain(100);
    checks++;
    if (rx_q.size() != 20) begin
      failures++;
      $display("FAIL full_order_count got %0d exp 20", rx_q.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        if (rx_q[i] !== {1'b0, 16'(i)}) begin
          failures++;
          $display("FAIL full_order idx=%0d got %h exp %h", i, rx_q[i], {1'b0, 16'(i)});
          break;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    rx_q.delete();
    for (int i = 0; i < 8; i++) src_q.push_back({1'b0, 16'(100 + i)});
    for (int c = 0; c < 8; c++) drive_cycle(0);
    for (int i = 8; i < 18; i++) src_q.push_back({1'b0, 16'(100 + i)});
    for (int c = 0; c < 10; c++) begin
      drive_cycle(100);
      checks++;
      if (fill_level !== 5'd8) begin
        failures++;
        $display("FAIL b2b_fill cyc=%0d got %0d exp 8", c, fill_level);
      end
    end
    drain(100);
    checks++;
    if (rx_q.size() != 18) begin
      failures++;
      $display("FAIL b2b_count got %0d exp 18", rx_q.size());
    end else begin
      for (int i = 0; i < 18; i++) begin
        if (rx_q[i] !== {1'b0, 16'(100 + i)}) begin
          failures++;
          $display("FAIL b2b_order idx=%0d got %h exp %h", i, rx_q[i], {1'b0, 16'(100 + i)});
          break;
        end
      end
    end
  endtask

  task automatic test_frame_stream();
    logic [DW:0] sent[$];
    int n = 0;
    int bad = 0;
    do_reset();
    rx_q.delete();
    for (int i = 0; i < 2048; i++) begin
      sent.push_back({(i == 2047), 16'($urandom)});
    end
    src_q = sent;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < 20000) begin
      drive_cycle(70);
      n++;
    end
    checks++;
    if (rx_q.size() != 2048) begin
      failures++;
      $display("FAIL stream_count got %0d exp 2048", rx_q.size());
    end else begin
      for (int i = 0; i < 2048; i++) if (rx_q[i] !== sent[i]) bad++;
      if (bad != 0) begin
        failures++;
        $display("FAIL stream_data got %0d bad beats exp 0", bad);
      end
    end
    checks++;
    if (frame_count !== 16'd1) begin
      failures++;
      $display("FAIL stream_frames got %0d exp 1", frame_count);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) src_q.push_back({1'b0, 16'($urandom)});
    for (int c = 0; c < 10; c++) drive_cycle(0);
    do_reset();
    src_q.delete();
    checks++;
    if (fill_level !== '0 || m_axis.tvalid !== 1'b0 || s_axis.tready !== 1'b1 || frame_count !== '0) begin
      failures++;
      $display("FAIL midreset got fill=%0d vld=%b rdy=%b fc=%0d exp 0 0 1 0",
               fill_level, m_axis.tvalid, s_axis.tready, frame_count);
    end
    src_q.push_back({1'b0, 16'hBEEF});
    drive_cycle(0);
    checks++;
    if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL midreset_first got vld=%b data=%h exp 1 beef", m_axis.tvalid, m_axis.tdata);
    end
    drain(50);
  endtask

  task automatic test_stalled_tlast();
    for (int i = 0; i < 16; i++) src_q.push_back({1'b0, 16'(200 + i)});
    for (int c = 0; c < 16; c++) drive_cycle(0);
    checks++;
    if (overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL stall_pre got %b exp 0", overflow_err);
    end
    src_q.push_back({1'b1, 16'hAAAA});
    drive_cycle(0);
    checks++;
    if (overflow_err !== 1'b1) begin
      failures++;
      $display("FAIL stall_set got %b exp 1", overflow_err);
    end
    drain(100);
    checks++;
    if (overflow_err !== 1'b1) begin
      failures++;
      $display("FAIL stall_sticky got %b exp 1", overflow_err);
    end
    do_reset();
    checks++;
    if (overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL stall_clear got %b exp 0", overflow_err);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_beat();
    test_fill_full();
    test_back_to_back();
    test_frame_stream();
    test_reset_mid();
    test_stalled_tlast();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_axis_out_fifo.md
Name: fir_axis_out_fifo

Overview:
- Synchronous AXI-Stream FIFO directly downstream of fir_module_n_stage_pipelined.
- Takes the FIR master stream (tdata/tvalid/tlast) and drives its m_axis_fir_tready, giving real backpressure instead of a tied-high ready.
- Presents a first-word-fall-through stream to the consumer.
- Counts completed frames (tlast beats) and reports fill level for debug and flow control.

Parameters:
DATA_WIDTH, 16, width of sample data (signed, passed through untouched)
ADDR_WIDTH, 4, log2 of storage depth; DEPTH = 2**ADDR_WIDTH = 16 entries
ALMOST_FULL_TH, 12, fill level at or above which almost_full is asserted (1..DEPTH)
FRAME_CNT_WIDTH, 16, width of completed-frame counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
s_axis_tdata  in  DATA_WIDTH  sample from FIR m_axis_fir_tdata
s_axis_tvalid  in  1  from FIR m_axis_fir_tvalid
s_axis_tlast  in  1  from FIR m_axis_fir_tlast
s_axis_tready  out  1  to FIR m_axis_fir_tready
m_axis_tdata  out  DATA_WIDTH  head-of-FIFO sample
m_axis_tvalid  out  1  FIFO non-empty
m_axis_tlast  out  1  tlast stored with head sample
m_axis_tready  in  1  consumer ready
fill_level  out  ADDR_WIDTH+1  entries currently stored, 0..DEPTH
almost_full  out  1  fill_level >= ALMOST_FULL_TH
frame_count  out  FRAME_CNT_WIDTH  number of tlast beats delivered on output
overflow_err  out  1  sticky: s_axis_tvalid high while s_axis_tready low AND s_axis_tlast high (frame end stalled), debug only

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+1) register array holding {tlast, tdata}; write pointer, read pointer (ADDR_WIDTH bits, wrap modulo DEPTH) and count register (ADDR_WIDTH+1 bits).
- push = s_axis_tvalid & s_axis_tready; pop = m_axis_tvalid & m_axis_tready.
- s_axis_tready = (count != DEPTH), combinational from the count register only; no dependence on m_axis_tready, so no combinational in-to-out path through ready.
- m_axis_tvalid = (count != 0); m_axis_tdata/m_axis_tlast = array[rd_ptr] (first-word-fall-through).
- Latency: a beat accepted at edge N is visible on m_axis at cycle N+1 when the FIFO was empty; throughput 1 beat/cycle sustained when both sides are ready.
- Count update: push only -> +1; pop only -> -1; push and pop in the same cycle -> unchanged, both pointers advance.
- Full (count = DEPTH): tready low, no write; a pop in that cycle frees a slot, and tready rises the following cycle. A simultaneous push is not possible when full.
- Empty (count = 0): tvalid low, tdata/tlast hold the stale array value (don't-care); a push does not bypass to the output the same cycle.
- Pointer wrap: DEPTH-1 -> 0 on advance; ordering preserved across wrap.
- AXI output rule: once m_axis_tvalid is high, tdata/tlast stay stable until pop.
- frame_count: +1 on every pop with m_axis_tlast = 1; wraps from 2**FRAME_CNT_WIDTH-1 to 0.
- overflow_err: set when s_axis_tvalid & !s_axis_tready & s_axis_tlast; cleared only by reset.
- fill_level = count; almost_full is combinational from count.
- Reset (any cycle, including mid-frame): pointers, count, frame_count and overflow_err go to 0. Stored data is discarded (array contents need not be cleared).
- Output values during and after reset: s_axis_tready = 1, m_axis_tvalid = 0, m_axis_tlast = 0 (masked while empty), fill_level = 0, almost_full = 0.

Test Plan:
- Single beat: reset, push 0x1234 with tlast=1, m_axis_tready=1 -> m_axis_tvalid=1 with data 0x1234 and tlast=1 exactly one cycle later; frame_count goes 0->1 after the pop; fill_level returns to 0.
- Fill to full: m_axis_tready=0, drive 20 consecutive beats 0..19 -> 16 accepted, s_axis_tready low from the cycle after the 16th push, fill_level=16, almost_full high from the 12th push; then m_axis_tready=1 -> outputs 0..15 in order, followed by beats 16..19 still held by the source.
- Simultaneous push/pop: prefill 8 entries, then both sides valid and ready for 10 cycles -> fill_level stays 8 throughout; output order is continuous.
- Frame streaming: 2048 FIR beats with tlast on the last beat, random 30% m_axis_tready stalls -> all 2048 samples delivered bit-exact and in order; frame_count=1; pointers wrap 128 times with no loss.
- Reset mid-operation: prefill 10 entries, assert reset for 1 cycle -> next cycle fill_level=0, m_axis_tvalid=0, s_axis_tready=1, frame_count=0; a new beat 0xBEEF is then output first.
- Stalled tlast: FIFO full, source holds tlast=1 beat valid -> overflow_err sets and stays 1 after draining, until reset.
